// File: rtl/shift_register_universal.sv
// Universal shift register: hold, logical/arithmetic shifts, rotates, parallel load and clear,
// with a saturating shift counter and a registered serial output.
module shift_register_universal #(
   parameter int unsigned             WIDTH       = 8,
   parameter logic [WIDTH-1:0]        RESET_VALUE = '0,
   parameter int unsigned             COUNT_WIDTH = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   enable,
   input  logic [2:0]             mode,
   input  logic                   serial_left_in,
   input  logic                   serial_right_in,
   input  logic [WIDTH-1:0]       data,
   output logic [WIDTH-1:0]       q,
   output logic                   serial_out,
   output logic [COUNT_WIDTH-1:0] shift_count,
   output logic                   zero
);

   typedef enum logic [2:0] {
      MODE_HOLD  = 3'b000,
      MODE_SHL   = 3'b001,
      MODE_SHR   = 3'b010,
      MODE_ROL   = 3'b011,
      MODE_ROR   = 3'b100,
      MODE_LOAD  = 3'b101,
      MODE_ASR   = 3'b110,
      MODE_CLEAR = 3'b111
   } mode_e;

   localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};

   logic [WIDTH-1:0]       q_next;
   logic                   serial_out_next;
   logic [COUNT_WIDTH-1:0] shift_count_next;
   logic                   shifting;

   // Next-state selection; disabled cycles fall through to hold.
   always_comb begin
      q_next           = q;
      serial_out_next  = serial_out;
      shift_count_next = shift_count;
      shifting         = 1'b0;
      if (enable) begin
         case (mode_e'(mode))
            MODE_SHL: begin
               q_next          = {q[WIDTH-2:0], serial_left_in};
               serial_out_next = q[WIDTH-1];
               shifting        = 1'b1;
            end
            MODE_SHR: begin
               q_next          = {serial_right_in, q[WIDTH-1:1]};
               serial_out_next = q[0];
               shifting        = 1'b1;
            end
            MODE_ROL: begin
               q_next          = {q[WIDTH-2:0], q[WIDTH-1]};
               serial_out_next = q[WIDTH-1];
               shifting        = 1'b1;
            end
            MODE_ROR: begin
               q_next          = {q[0], q[WIDTH-1:1]};
               serial_out_next = q[0];
               shifting        = 1'b1;
            end
            MODE_ASR: begin
               q_next          = {q[WIDTH-1], q[WIDTH-1:1]};
               serial_out_next = q[0];
               shifting        = 1'b1;
            end
            MODE_LOAD: begin
               q_next           = data;
               shift_count_next = '0;
            end
            MODE_CLEAR: begin
               q_next           = '0;
               shift_count_next = '0;
            end
            default: ;
         endcase
      end
      // Counter saturates instead of wrapping.
      if (shifting && (shift_count != COUNT_MAX)) begin
         shift_count_next = shift_count + COUNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         q           <= RESET_VALUE;
         serial_out  <= 1'b0;
         shift_count <= '0;
      end else begin
         q           <= q_next;
         serial_out  <= serial_out_next;
         shift_count <= shift_count_next;
      end
   end

   assign zero = (q == '0);

endmodule

// File: doc/shift_register_universal.md
SHIFT_REGISTER_UNIVERSAL -- requirements
Module: shift_register_universal

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, register width in bits (legal range 2..64).
REQ-002 The block SHALL have parameter RESET_VALUE, default 0, WIDTH-bit value loaded into q on reset.
REQ-003 The block SHALL have parameter COUNT_WIDTH, default 4, width of the shift counter.
REQ-004 The block SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-005 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 The block SHALL have port enable  input  1  operation qualifier; low = hold.
REQ-007 The block SHALL have port mode  input  3  operation select (REQ-012).
REQ-008 The block SHALL have port serial_left_in  input  1  bit entering LSB on shift left.
REQ-009 The block SHALL have port serial_right_in  input  1  bit entering MSB on logical shift right.
REQ-010 The block SHALL have port data  input  WIDTH  parallel load value.
REQ-011 The block SHALL have outputs: q (output, WIDTH, register contents); serial_out (output, 1, bit shifted out on the last shifting cycle); shift_count (output, COUNT_WIDTH, shifts since last load/clear); zero (output, 1, high when q is all zeros, combinational from q).

Function
REQ-012 With enable=1, mode SHALL select: 000 hold; 001 shift left (q <= {q[W-2:0], serial_left_in}); 010 logical shift right (q <= {serial_right_in, q[W-1:1]}); 011 rotate left; 100 rotate right; 101 parallel load (q <= data); 110 arithmetic shift right (MSB replicated); 111 clear (q <= 0).
REQ-013 With enable=0, q, serial_out and shift_count SHALL hold regardless of mode.
REQ-014 All q updates SHALL take effect one clock after the sampled inputs; no combinational path from data to q.
REQ-015 On shift left/rotate left, serial_out SHALL capture the old q[W-1]; on shift right/rotate right/arithmetic right, the old q[0].
REQ-016 serial_out SHALL hold its value during hold, load, clear and enable=0 cycles.
REQ-017 shift_count SHALL increment by 1 on every enabled cycle with mode 001, 010, 011, 100 or 110.
REQ-018 shift_count SHALL saturate at 2^COUNT_WIDTH-1 and not wrap.
REQ-019 shift_count SHALL clear to 0 on parallel load (101) and clear (111); it SHALL hold on hold (000).
REQ-020 Rotating WIDTH times from any value SHALL return q to its original value.
REQ-021 zero SHALL reflect the current q only, including directly after reset if RESET_VALUE=0.

Reset
REQ-022 When reset=1 at a rising clock edge, q SHALL become RESET_VALUE, serial_out 0, shift_count 0, regardless of enable, mode or data.
REQ-023 Reset SHALL have priority over every mode; asserting reset mid-sequence SHALL discard the in-progress operation with no residual effect.
REQ-024 Between rising edges, reset changes SHALL NOT affect any output (no asynchronous path).
REQ-025 Before the first clock edge with reset=1, output values are undefined and SHALL NOT be checked.

Verification
REQ-026 Reset: reset=1, enable=1, mode=101, data=8'hFF for one edge -> q=8'h00, shift_count=0, serial_out=0, zero=1; reset asserted between edges -> no output change until next edge.
REQ-027 Load and shift: load 8'hA5, then 3 shifts left with serial_left_in=1 -> q=8'h2F, serial_out=1, shift_count=3.
REQ-028 Arithmetic vs logical right: load 8'h80; mode 110 twice -> q=8'hE0; reload 8'h80; mode 010 twice with serial_right_in=0 -> q=8'h20, serial_out=0.
REQ-029 Rotate: load 8'h81; 8 rotate-right cycles -> q=8'h81, shift_count=8; one rotate left -> q=8'h03, serial_out=1.
REQ-030 Saturation and enable: COUNT_WIDTH=4, 20 shift cycles -> shift_count=15; then enable=0 with mode=111 -> q, shift_count unchanged; enable=1 mode=111 -> q=0, shift_count=0, zero=1.
REQ-031 Parameters: WIDTH=16, RESET_VALUE=16'h1234 -> reset yields q=16'h1234, zero=0; one shift left with serial_left_in=0 -> q=16'h2468.
